wei_flg_dist: RTL and testbench

Parametrised weight-flag distributor. Takes one valid/ready flag stream from the global buffer and routes it to NUM_PE PE-block consumers in ascending index order. Each enabled PE receives a fixed burst of beats before the block moves to the next PE. Adds over the previous generation:
- runtime burst length
- per-PE enable mask, so disabled PEs are skipped
- start/done job framing
- an optional registered output stage

---
 rtl/wei_flg_dist_if.sv | 23 ++
 rtl/wei_flg_dist.sv | 208 ++++++++++++++++++++
 tb/tb_wei_flg_dist.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wei_flg_dist_if.sv
// Flag-stream bundle for the weight-flag distributor.
// master = distributor side; slave = source/PE side.
interface wei_flg_dist_if #(
  parameter int NUM_PE = 16,
  parameter int DW     = 32
);
  logic              s_val;
  logic              s_rdy;
  logic [DW-1:0]     s_dat;
  logic [NUM_PE-1:0] m_val;
  logic [NUM_PE-1:0] m_rdy;
  logic [DW-1:0]     m_dat;

  modport master (
    input  s_val, s_dat, m_rdy,
    output s_rdy, m_val, m_dat
  );

  modport slave (
    output s_val, s_dat, m_rdy,
    input  s_rdy, m_val, m_dat
  );
endinterface

// File: rtl/wei_flg_dist.sv
// Weight-flag distributor: routes one flag stream to NUM_PE PEs,
// a burst of beats per enabled PE, in ascending index order.
// Ports: clk, rst_n (async, active low); cfg_start/cfg_pe_en/cfg_beats
// job setup; bus (s_* source side, m_* PE side); cur_pe, busy, done.
// Option: define WEI_FLG_DIST_SKID_EN for a 2-entry registered
// skid stage; default is a zero-latency pass-through.
module wei_flg_dist #(
  parameter int NUM_PE       = 16,
  parameter int BEATS_PER_PE = 14,
  parameter int DW           = 32,
  parameter int PE_W         = $clog2(NUM_PE),
  parameter int BEAT_W       = ($clog2(BEATS_PER_PE + 1) < 4) ?
                               4 : $clog2(BEATS_PER_PE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [NUM_PE-1:0] cfg_pe_en,
  input  logic [BEAT_W-1:0] cfg_beats,
  wei_flg_dist_if.master    bus,
  output logic [PE_W-1:0]   cur_pe,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, XFER, FIN} st_e;

  localparam logic [BEAT_W-1:0] DEF_BEATS = BEAT_W'(BEATS_PER_PE);

  st_e               state_q;
  logic [PE_W-1:0]   cur_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beats_q;
  logic [NUM_PE-1:0] mask_q;
  logic              busy_q;
  logic              done_q;

  logic [PE_W:0]     first_en;
  logic [PE_W:0]     nxt;
  logic              acc;
  logic              last_beat;
  logic              src_end;
  logic              fin_go;

  // Lowest set bit at or above lo; MSB of result flags "found".
  function automatic logic [PE_W:0] first_from(
    input logic [NUM_PE-1:0] m,
    input int                lo
  );
    logic [PE_W:0] r;
    r = '0;
    for (int i = NUM_PE - 1; i >= 0; i--)
      if (i >= lo && m[i]) r = {1'b1, PE_W'(i)};
    return r;
  endfunction

  assign first_en  = first_from(cfg_pe_en, 0);
  assign nxt       = first_from(mask_q, int'(cur_q) + 1);
  assign last_beat = acc & (beat_q == beats_q - 1'b1);
  assign src_end   = last_beat & ~nxt[PE_W];

  assign cur_pe = cur_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef WEI_FLG_DIST_SKID_EN
  logic            s_rdy_q;
  logic            src_fin_q;
  logic            hd_v_q, hd_v_d;
  logic [DW-1:0]   hd_d_q, hd_d_d;
  logic [PE_W-1:0] hd_t_q, hd_t_d;
  logic            tl_v_q, tl_v_d;
  logic [DW-1:0]   tl_d_q, tl_d_d;
  logic [PE_W-1:0] tl_t_q, tl_t_d;
  logic            pop;
  logic            s_rdy_d;

  assign acc    = (state_q == XFER) & bus.s_val & s_rdy_q;
  assign pop    = hd_v_q & bus.m_rdy[hd_t_q];
  // All source beats taken: leave only once the buffer has drained.
  assign fin_go = src_fin_q & ~hd_v_d;

  always_comb begin
    hd_v_d = hd_v_q;
    hd_d_d = hd_d_q;
    hd_t_d = hd_t_q;
    tl_v_d = tl_v_q;
    tl_d_d = tl_d_q;
    tl_t_d = tl_t_q;
    if (pop) begin
      hd_v_d = tl_v_q;
      hd_d_d = tl_d_q;
      hd_t_d = tl_t_q;
      tl_v_d = 1'b0;
    end
    if (acc) begin
      if (hd_v_d) begin
        tl_v_d = 1'b1;
        tl_d_d = bus.s_dat;
        tl_t_d = cur_q;
      end else begin
        hd_v_d = 1'b1;
        hd_d_d = bus.s_dat;
        hd_t_d = cur_q;
      end
    end
  end

  assign s_rdy_d = ~tl_v_d &
    ((state_q == IDLE & cfg_start & first_en[PE_W]) |
     (state_q == XFER & ~src_end & ~src_fin_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_v_q  <= 1'b0;
      hd_d_q  <= '0;
      hd_t_q  <= '0;
      tl_v_q  <= 1'b0;
      tl_d_q  <= '0;
      tl_t_q  <= '0;
      s_rdy_q <= 1'b0;
    end else begin
      hd_v_q  <= hd_v_d;
      hd_d_q  <= hd_d_d;
      hd_t_q  <= hd_t_d;
      tl_v_q  <= tl_v_d;
      tl_d_q  <= tl_d_d;
      tl_t_q  <= tl_t_d;
      s_rdy_q <= s_rdy_d;
    end
  end

  always_comb begin
    bus.m_val = '0;
    if (hd_v_q) bus.m_val[hd_t_q] = 1'b1;
  end
  assign bus.m_dat = hd_d_q;
  assign bus.s_rdy = s_rdy_q;
`else
  assign acc    = bus.s_val & bus.s_rdy;
  assign fin_go = src_end;

  always_comb begin
    bus.m_val = '0;
    if (state_q == XFER) bus.m_val[cur_q] = bus.s_val;
  end
  assign bus.s_rdy = (state_q == XFER) & bus.m_rdy[cur_q];
  assign bus.m_dat = bus.s_dat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      beat_q    <= '0;
      beats_q   <= '0;
      mask_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef WEI_FLG_DIST_SKID_EN
      src_fin_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (cfg_start) begin
          mask_q  <= cfg_pe_en;
          beats_q <= (cfg_beats != '0) ? cfg_beats : DEF_BEATS;
          cur_q   <= first_en[PE_W-1:0];
          beat_q  <= '0;
          busy_q  <= 1'b1;
`ifdef WEI_FLG_DIST_SKID_EN
          src_fin_q <= 1'b0;
`endif
          if (first_en[PE_W]) begin
            state_q <= XFER;
          end else begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        XFER: begin
          if (acc) begin
            if (last_beat) begin
              beat_q <= '0;
              if (nxt[PE_W]) cur_q <= nxt[PE_W-1:0];
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
`ifdef WEI_FLG_DIST_SKID_EN
          if (src_end) src_fin_q <= 1'b1;
`endif
          if (fin_go) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wei_flg_dist.sv
// Bench for wei_flg_dist: directed jobs, per-PE scoreboard of
// expected (pe, data) beats, done/busy framing checks.
`timescale 1ns/1ps
module tb_wei_flg_dist;
  localparam int NUM_PE = 16;
  localparam int BPP    = 14;
  localparam int DW     = 32;
  localparam int PE_W   = 4;
  localparam int BEAT_W = 4;

  typedef struct packed {
    logic [PE_W-1:0] pe;
    logic [DW-1:0]   dat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic [NUM_PE-1:0] cfg_pe_en = '0;
  logic [BEAT_W-1:0] cfg_beats = '0;
  logic [PE_W-1:0]   cur_pe;
  logic              busy;
  logic              done;

  wei_flg_dist_if #(.NUM_PE(NUM_PE), .DW(DW)) bus ();

  wei_flg_dist #(
    .NUM_PE(NUM_PE), .BEATS_PER_PE(BPP), .DW(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_pe_en(cfg_pe_en),
    .cfg_beats(cfg_beats), .bus(bus),
    .cur_pe(cur_pe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  int            vec = 0;
  int            errs = 0;
  int            cyc = 0;
  int            jcyc = 0;
  int            hs_total, last_hs, done_cyc, done_n;
  int            busy_n, srdy_n;
  logic [DW-1:0] src_cnt = 32'h1000;
  logic [15:0]   job_mask = '0;
  bit            rnd_src = 0;
  bit            start_on_done = 0;
  int            bp_from = -1, bp_to = -1;
  int            poke_at = -1;
  int            abort_at = -1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, observe at negedge.
  task automatic step();
    exp_t e;
    bit   bp;
    @(posedge clk); #1;
    cyc++;
    jcyc++;
    bp = (jcyc >= bp_from) && (jcyc < bp_to);
    if (jcyc == poke_at) begin
      cfg_start = 1'b1;
      cfg_pe_en = 16'h0F0F;
      cfg_beats = 4'd1;
    end else begin
      cfg_start = 1'b0;
    end
    if (bp) begin
      bus.m_rdy = NUM_PE'($urandom);
      bus.m_rdy[cur_pe] = 1'b0;
    end else begin
      bus.m_rdy = '1;
    end
    bus.s_val = rnd_src ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.s_dat = src_cnt;
    @(negedge clk);
    chk("mval_onehot", 64'($onehot0(bus.m_val)), 64'd1);
    chk("mval_mask", 64'(bus.m_val & ~job_mask), 64'd0);
    if (bp) chk("bp_srdy", 64'(bus.s_rdy), 64'd0);
    for (int k = 0; k < NUM_PE; k++) begin
      if (bus.m_val[k] && bus.m_rdy[k]) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 64'(k), 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("beat_pe", 64'(k), 64'(e.pe));
          chk("beat_dat", 64'(bus.m_dat), 64'(e.dat));
        end
        hs_total++;
        last_hs = cyc;
      end
    end
    if (bus.s_val && bus.s_rdy) src_cnt++;
    if (busy) busy_n++;
    if (bus.s_rdy) srdy_n++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
      if (start_on_done) begin
        cfg_start = 1'b1;
        cfg_pe_en = 16'h0001;
      end
    end
  endtask

  task automatic run_job(input logic [15:0] mask,
                         input logic [3:0] beats, input int budget);
    int nb;
    int idx;
    nb  = (beats == 0) ? BPP : int'(beats);
    idx = 0;
    for (int k = 0; k < NUM_PE; k++)
      if (mask[k])
        for (int b = 0; b < nb; b++) begin
          sb.push_back(exp_t'{pe: PE_W'(k), dat: src_cnt + DW'(idx)});
          idx++;
        end
    job_mask = mask;
    hs_total = 0;
    done_n   = 0;
    busy_n   = 0;
    srdy_n   = 0;
    jcyc     = 0;
    last_hs  = -1;
    done_cyc = -1;
    cfg_pe_en = mask;
    cfg_beats = beats;
    cfg_start = 1'b1;
    do step();
    while (done_n == 0 && jcyc < budget &&
           !(abort_at >= 0 && hs_total >= abort_at));
    if (abort_at >= 0) return;
    step();
    chk("done_once", 64'(done_n), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("beats_total", 64'(hs_total), 64'(idx));
    if (hs_total > 0)
      chk("done_timing", 64'(done_cyc), 64'(last_hs + 1));
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    bus.s_val = 1'b0;
    bus.s_dat = '0;
    bus.m_rdy = '0;
    repeat (3) @(negedge clk);
    chk("rst_mval", 64'(bus.m_val), 64'd0);
    chk("rst_srdy", 64'(bus.s_rdy), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_curpe", 64'(cur_pe), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default burst over all PEs.
    run_job(16'hFFFF, 4'd0, 300);

    // Sparse mask, bursty source, start coinciding with done.
    rnd_src = 1;
    start_on_done = 1;
    run_job(16'h8421, 4'd3, 100);
    start_on_done = 0;
    rnd_src = 0;
    step();
    chk("start_at_done_ign", 64'(busy), 64'd0);

    // Selected PE stalls for 5 cycles mid-burst.
    bp_from = 6;
    bp_to   = 11;
    run_job(16'h0006, 4'd8, 60);
    bp_from = -1;
    bp_to   = -1;

    // Empty mask.
    run_job(16'h0000, 4'd5, 10);
    chk("empty_busy_cyc", 64'(busy_n), 64'd1);
    chk("empty_srdy", 64'(srdy_n), 64'd0);

    // Start pulse while busy is ignored.
    poke_at = 10;
    run_job(16'h00F0, 4'd5, 60);
    poke_at = -1;

    // Boundary masks and burst lengths.
    run_job(16'h8000, 4'd1, 10);
    run_job(16'h0001, 4'd15, 30);

    // Async reset at PE3 beat 7, then a fresh job.
    abort_at = 3 * BPP + 7;
    run_job(16'hFFFF, 4'd0, 100);
    abort_at = -1;
    chk("abort_point", 64'(hs_total), 64'(3 * BPP + 7));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mval", 64'(bus.m_val), 64'd0);
    chk("arst_srdy", 64'(bus.s_rdy), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_curpe", 64'(cur_pe), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(16'hFFFF, 4'd2, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
